// File: rtl/rv_pkg.sv
// Shared encodings and defaults for the RV64I execute stage.
package rv_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned PC_W_DEF = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/rv_regfile.sv
// 32-entry integer register file: two operand reads, one debug read, one write; x0 reads zero.
module rv_regfile #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock_1hz,
  input  logic            reset_n,
  input  logic [4:0]      rs1_sel_i,
  input  logic [4:0]      rs2_sel_i,
  input  logic [4:0]      dbg_sel_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_sel_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clock_1hz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (wr_sel_i != 5'd0)) begin
      regs_q[wr_sel_i] <= wr_data_i;
    end
  end

  assign rs1_data_o = (rs1_sel_i == 5'd0) ? '0 : regs_q[rs1_sel_i];
  assign rs2_data_o = (rs2_sel_i == 5'd0) ? '0 : regs_q[rs2_sel_i];
  assign dbg_data_o = (dbg_sel_i == 5'd0) ? '0 : regs_q[dbg_sel_i];

endmodule

// File: rtl/rv_exec_stage.sv
// Execute/write-back stage: accepts one instruction, executes it in EXEC, retires or halts.
module rv_exec_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clock_1hz,
  input  logic            reset_n,
  input  logic            ir_valid,
  input  logic [31:0]     ir,
  input  logic [PC_W-1:0] ir_pc,
  output logic            ir_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            retired,
  output logic            illegal,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [1:0]      state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            retired_q, retired_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j, pc_x, op_b, alu_res;
  logic [XLEN-1:0] result, target_x;
  logic            legal, wr_en, taken, rf_we;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_x  = {{(XLEN-PC_W){1'b0}}, pc_q};
  assign op_b  = (opcode == OPC_OP) ? rs2_val : imm_i;

  always_comb begin
    alu_res = '0;
    case (funct3)
      F3_ADD:  alu_res = (opcode == OPC_OP && funct7 == F7_SUB) ? rs1_val - op_b : rs1_val + op_b;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
      F3_XOR:  alu_res = rs1_val ^ op_b;
      F3_OR:   alu_res = rs1_val | op_b;
      F3_AND:  alu_res = rs1_val & op_b;
      default: alu_res = '0;
    endcase
  end

  // Jump/branch targets come from the operands read this cycle, so a JALR with rd==rs1 sees the old rs1.
  always_comb begin
    legal    = 1'b0;
    wr_en    = 1'b0;
    taken    = 1'b0;
    result   = '0;
    target_x = '0;
    case (opcode)
      OPC_LUI:   begin legal = 1'b1; wr_en = 1'b1; result = imm_u; end
      OPC_AUIPC: begin legal = 1'b1; wr_en = 1'b1; result = pc_x + imm_u; end
      OPC_JAL: begin
        legal = 1'b1; wr_en = 1'b1; taken = 1'b1;
        result = pc_x + FOUR; target_x = pc_x + imm_j;
      end
      OPC_JALR: begin
        legal = (funct3 == F3_JALR); wr_en = legal; taken = legal;
        result = pc_x + FOUR; target_x = (rs1_val + imm_i) & LSB_MASK;
      end
      OPC_BRANCH: begin
        target_x = pc_x + imm_b;
        case (funct3)
          F3_BEQ:  begin legal = 1'b1; taken = (rs1_val == rs2_val); end
          F3_BNE:  begin legal = 1'b1; taken = (rs1_val != rs2_val); end
          F3_BLT:  begin legal = 1'b1; taken = ($signed(rs1_val) <  $signed(rs2_val)); end
          F3_BGE:  begin legal = 1'b1; taken = ($signed(rs1_val) >= $signed(rs2_val)); end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = (funct3 == F3_ADD) || (funct3 == F3_SLT) || (funct3 == F3_XOR) ||
                (funct3 == F3_OR)  || (funct3 == F3_AND);
        wr_en = legal; result = alu_res;
      end
      OPC_OP: begin
        legal = ((funct7 == F7_BASE) &&
                 ((funct3 == F3_ADD) || (funct3 == F3_SLT) || (funct3 == F3_XOR) ||
                  (funct3 == F3_OR)  || (funct3 == F3_AND))) ||
                ((funct7 == F7_SUB) && (funct3 == F3_ADD));
        wr_en = legal; result = alu_res;
      end
      default: legal = 1'b0;
    endcase
  end

  assign rf_we = (state_q == ST_EXEC) && legal && wr_en;

  rv_regfile #(.XLEN(XLEN)) u_regfile (
    .clock_1hz  (clock_1hz),
    .reset_n    (reset_n),
    .rs1_sel_i  (rs1),
    .rs2_sel_i  (rs2),
    .dbg_sel_i  (dbg_sel),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .wr_sel_i   (rd),
    .wr_data_i  (result)
  );

  assign ir_ready = (state_q == ST_IDLE) && !redirect_valid_q;

  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    pc_d             = pc_q;
    retired_d        = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    illegal_d        = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (ir_valid && ir_ready) begin
          ir_d    = ir;
          pc_d    = ir_pc;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (legal) begin
          retired_d        = 1'b1;
          redirect_valid_d = taken;
          if (taken) redirect_pc_d = target_x[PC_W-1:0];
          state_d = ST_IDLE;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_1hz or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      ir_q             <= '0;
      pc_q             <= '0;
      retired_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      ir_q             <= ir_d;
      pc_q             <= pc_d;
      retired_q        <= retired_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_q        <= illegal_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign retired        = retired_q;
  assign illegal        = illegal_q;

endmodule

// File: doc/rv_exec_stage.md
# rv_exec_stage

Execute/write-back stage fed by the instruction fetch stage of the on-board CPU. It accepts one 32-bit RV64I instruction plus its PC over a valid/ready handshake. It executes a fixed integer subset against a 32×64 register file and retires it. Taken control transfers go back to fetch as a one-cycle redirect. A debug read port drives the board LEDs and the bench.

## Interface
- XLEN, 64, register/datapath width.
- PC_W, 32, PC and redirect width.
- clock_1hz  in  1  stage clock (slow board clock).
- reset_n  in  1  reset, asynchronous, active-low.
- ir_valid  in  1  fetch presents ir/ir_pc.
- ir  in  32  instruction word.
- ir_pc  in  PC_W  address of ir.
- ir_ready  out  1  stage can accept; equals (state==IDLE) && !redirect_valid.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  PC_W  new fetch address.
- retired  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky; set on unsupported encoding.
- dbg_sel  in  5  register index for debug read.
- dbg_data  out  XLEN  combinational read of x[dbg_sel]; 0 when dbg_sel==0.

## Operation
- States: IDLE, EXEC, HALT.
- IDLE: accept on ir_valid && ir_ready, latch ir/ir_pc, go to EXEC.
- EXEC: decode, read rs1/rs2, compute the result, write rd if rd!=0, then go to IDLE. On an unsupported opcode/funct, make no write, set illegal, and go to HALT.
- HALT: ir_ready=0, no outputs pulse; left only by reset.
- Supported: LUI, AUIPC, ADDI, SLTI, XORI, ORI, ANDI, ADD, SUB, SLT, XOR, OR, AND, JAL, JALR, BEQ, BNE, BLT, BGE. All other encodings are illegal, including all-zero.
- Arithmetic: immediates are sign-extended to XLEN. PC is zero-extended to XLEN. Add/sub wrap modulo 2^XLEN. SLT/SLTI/BLT/BGE are signed.
- LUI: rd = sext(imm_u).
- AUIPC: rd = pc + sext(imm_u).
- JAL: rd = pc+4; target = pc+imm_j.
- JALR: rd = pc+4; target = (rs1+imm_i) & ~1. Compute the target before the rd write, so rd==rs1 uses the old rs1.
- Branch taken: target = pc+imm_b. Not taken: no redirect; fetch continues sequentially.
- Targets are truncated to PC_W bits, with wrap-around.
- x0 reads 0 always; writes to x0 are discarded.

## Timing
- Reset values: state=IDLE, all registers 0, redirect_valid=0, redirect_pc=0, retired=0, illegal=0. ir_ready=1 after reset release.
- Accept at edge N.
  - EXEC occupies cycle N..N+1.
  - Register-file write, retired, and redirect are registered at edge N+1, so visible in cycle after N+1.
  - Throughput: one instruction per 2 cycles.
- retired and redirect_valid are high exactly one cycle, simultaneously, for jumps and taken branches.
- In the redirect cycle ir_ready=0, so an in-flight stale fetch is never accepted. Fetch must flush it.
- ir_valid while ir_ready=0: ignored. Fetch holds its data; no requirement on stability.
- Reset mid-EXEC: instruction abandoned, no write, no pulse. All outputs take reset values asynchronously.
- dbg_data reflects a write from the cycle after the write edge.

## Structure
- Package rv_pkg:
  - opcode constants (LUI, AUIPC, OP_IMM, OP, JAL, JALR, BRANCH)
  - funct3/funct7 constants
  - the IDLE/EXEC/HALT state encoding
  - XLEN/PC_W defaults
- Sub-module rv_regfile:
  - 32×XLEN storage
  - two read ports plus one debug read port
  - one synchronous write port
  - x0 hardwired to 0
- Decode, immediate generation, ALU, branch compare and FSM live in rv_exec_stage.

## Test plan
- Reset, then LUI x1,0x12345 (0x123450B7) -> retired pulses once; dbg_sel=1 reads 0x0000000012345000; redirect_valid stays 0.
- ADDI x2,x0,-1 (0xFFF00113) then ADD x3,x2,x2 (0x002101B3) -> x2=0xFFFFFFFFFFFFFFFF, x3=0xFFFFFFFFFFFFFFFE.
- BEQ x0,x0,+8 (0x00000463) at pc 0x10 -> redirect_valid=1 with redirect_pc=0x18 for one cycle; ir_ready=0 that cycle while ir_valid=1.
- JAL x1,+16 (0x010000EF) at pc 0x20 -> x1=0x24, redirect_pc=0x30.
- ADDI x0,x0,5 (0x00500013) -> retired pulses; dbg_sel=0 reads 0.
- ir=0x00000000 -> illegal=1, ir_ready=0 for 10+ cycles until reset. Separately, reset_n low during EXEC of LUI x1 -> x1 stays 0 and all outputs return to reset values.
